// File: rtl/ret_stack_pkg.sv
// Shared CPU parameter defaults for the return-address stack.
package ret_stack_pkg;

  localparam int unsigned DefCntrWidth = 8;
  localparam int unsigned DefRegBitCnt = 3;
  localparam int unsigned DefPtrWidth  = DefRegBitCnt + 1;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack: call pushes the PC, return pops it and
// presents PC+1 with a one-cycle jump strobe; sticky overflow/underflow flags.
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH  = DefCntrWidth,
  parameter int unsigned REG_BIT_CNT = DefRegBitCnt
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cal_f_i,
  input  logic                   ret_f_i,
  input  logic                   err_clr_i,
  input  logic [CNTR_WIDTH-1:0]  counter_i,
  output logic [CNTR_WIDTH-1:0]  ret_addr_o,
  output logic                   ret_jmp_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [REG_BIT_CNT:0]   depth_o,
  output logic                   ovf_err_o,
  output logic                   unf_err_o
);

  localparam int unsigned Depth = 1 << REG_BIT_CNT;
  localparam int unsigned PtrW  = REG_BIT_CNT + 1;
  localparam logic [PtrW-1:0] DepthMax = PtrW'(Depth);

  logic [CNTR_WIDTH-1:0]  mem_q [Depth];
  logic [PtrW-1:0]        depth_q, depth_d;
  logic [CNTR_WIDTH-1:0]  ret_addr_q, ret_addr_d;
  logic                   ret_jmp_q, ret_jmp_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic                   ovf_set, unf_set;
  logic                   empty, full, wr_en;
  logic [REG_BIT_CNT-1:0] top_idx, wr_idx;

  assign empty = (depth_q == '0);
  assign full  = (depth_q == DepthMax);
  // Low bits minus one also yields the right index when full (wraps to Depth-1).
  assign top_idx = depth_q[REG_BIT_CNT-1:0] - REG_BIT_CNT'(1);

  always_comb begin
    depth_d    = depth_q;
    ret_addr_d = ret_addr_q;
    ret_jmp_d  = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = depth_q[REG_BIT_CNT-1:0];
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    if (ret_f_i) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        ret_jmp_d  = 1'b1;
        ret_addr_d = mem_q[top_idx] + CNTR_WIDTH'(1);
      end
    end

    if (cal_f_i) begin
      if (ret_f_i && !empty) begin
        // Call and return together: overwrite the entry just popped.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        depth_d = depth_q + PtrW'(1);
      end
    end else if (ret_f_i && !empty) begin
      depth_d = depth_q - PtrW'(1);
    end

    ovf_d = ovf_set | (ovf_q & ~err_clr_i);
    unf_d = unf_set | (unf_q & ~err_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q    <= '0;
      ret_addr_q <= '0;
      ret_jmp_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      depth_q    <= depth_d;
      ret_addr_q <= ret_addr_d;
      ret_jmp_q  <= ret_jmp_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Entry storage is not reset; entries above the top are never read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= counter_i;
    end
  end

  assign ret_addr_o = ret_addr_q;
  assign ret_jmp_o  = ret_jmp_q;
  assign empty_o    = empty;
  assign full_o     = full;
  assign depth_o    = depth_q;
  assign ovf_err_o  = ovf_q;
  assign unf_err_o  = unf_q;

endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack: a queue-based stack model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_ret_stack;

  logic       clk;
  logic       rst_n;
  logic       cal_f, ret_f, err_clr;
  logic [7:0] counter;
  logic [7:0] ret_addr;
  logic       ret_jmp, empty, full, ovf_err, unf_err;
  logic [3:0] depth;

  ret_stack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cal_f_i    (cal_f),
    .ret_f_i    (ret_f),
    .err_clr_i  (err_clr),
    .counter_i  (counter),
    .ret_addr_o (ret_addr),
    .ret_jmp_o  (ret_jmp),
    .empty_o    (empty),
    .full_o     (full),
    .depth_o    (depth),
    .ovf_err_o  (ovf_err),
    .unf_err_o  (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: a plain queue as the stack.
  logic [7:0] stk[$];
  logic [7:0] m_ret_addr;
  bit         m_jmp, m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_ret_addr = 8'h00;
    m_jmp      = 1'b0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic r, input logic e, input logic [7:0] cnt);
    bit ovf_set = 1'b0;
    bit unf_set = 1'b0;
    m_jmp = 1'b0;
    if (r) begin
      if (stk.size() == 0) begin
        unf_set = 1'b1;
      end else begin
        m_ret_addr = stk.pop_back() + 8'd1;
        m_jmp      = 1'b1;
      end
    end
    if (c) begin
      if (stk.size() < 8) stk.push_back(cnt);
      else ovf_set = 1'b1;
    end
    m_ovf = ovf_set | (m_ovf & ~e);
    m_unf = unf_set | (m_unf & ~e);
  endtask

  task automatic compare_all();
    chk("depth", int'(depth), stk.size());
    chk("empty", int'(empty), int'(stk.size() == 0));
    chk("full", int'(full), int'(stk.size() == 8));
    chk("ret_jmp", int'(ret_jmp), int'(m_jmp));
    chk("ret_addr", int'(ret_addr), int'(m_ret_addr));
    chk("ovf_err", int'(ovf_err), int'(m_ovf));
    chk("unf_err", int'(unf_err), int'(m_unf));
  endtask

  always @(negedge clk) begin
    if (chk_en) compare_all();
  end

  // Apply inputs for one cycle; outputs are settled on return (posedge + 1).
  task automatic step(input logic c, input logic r, input logic e, input logic [7:0] cnt);
    cal_f   = c;
    ret_f   = r;
    err_clr = e;
    counter = cnt;
    @(posedge clk);
    model_step(c, r, e, cnt);
    #1;
    cal_f   = 1'b0;
    ret_f   = 1'b0;
    err_clr = 1'b0;
    counter = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected done by t=100000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; cal_f = 1'b0; ret_f = 1'b0; err_clr = 1'b0; counter = 8'h00;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_jmp", int'(ret_jmp), 0);
    chk("rst_addr", int'(ret_addr), 0);
    chk("rst_errs", int'({ovf_err, unf_err}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic push/pop ordering and back-to-back pops.
    step(1, 0, 0, 8'h10);
    step(1, 0, 0, 8'h20);
    step(1, 0, 0, 8'h30);
    chk("push3_depth", int'(depth), 3);
    step(0, 1, 0, 8'h00);
    chk("pop1_addr", int'(ret_addr), 8'h31);
    chk("pop1_jmp", int'(ret_jmp), 1);
    step(0, 1, 0, 8'h00);
    chk("pop2_addr", int'(ret_addr), 8'h21);
    step(0, 1, 0, 8'h00);
    chk("pop3_addr", int'(ret_addr), 8'h11);
    chk("pop3_jmp", int'(ret_jmp), 1);
    chk("pop3_empty", int'(empty), 1);
    step(0, 0, 0, 8'h00);
    chk("idle_jmp", int'(ret_jmp), 0);
    chk("idle_hold", int'(ret_addr), 8'h11);

    // Underflow and error clear.
    step(0, 1, 0, 8'h00);
    chk("unf_set", int'(unf_err), 1);
    chk("unf_nojmp", int'(ret_jmp), 0);
    chk("unf_hold", int'(ret_addr), 8'h11);
    step(0, 0, 1, 8'h00);
    chk("unf_clr", int'(unf_err), 0);

    // Fill, overflow, and set-wins-over-clear.
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 8'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_depth", int'(depth), 8);
    step(1, 0, 0, 8'h99);
    chk("ovf_set", int'(ovf_err), 1);
    chk("ovf_depth", int'(depth), 8);
    step(0, 1, 0, 8'h00);
    chk("ovf_pop", int'(ret_addr), 8'h09);
    step(1, 0, 0, 8'h0A);
    step(1, 0, 1, 8'h77);
    chk("set_wins", int'(ovf_err), 1);
    step(0, 0, 1, 8'h00);
    chk("ovf_clr", int'(ovf_err), 0);
    step(1, 1, 0, 8'h55);
    chk("fullcr_addr", int'(ret_addr), 8'h0B);
    chk("fullcr_ovf", int'(ovf_err), 0);
    chk("fullcr_depth", int'(depth), 8);
    step(0, 1, 0, 8'h00);
    chk("replaced_top", int'(ret_addr), 8'h56);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 8'h00);
    chk("drain_addr", int'(ret_addr), 8'h02);
    chk("drain_empty", int'(empty), 1);

    // Call+return while empty.
    step(1, 1, 0, 8'h33);
    chk("ecr_unf", int'(unf_err), 1);
    chk("ecr_jmp", int'(ret_jmp), 0);
    chk("ecr_depth", int'(depth), 1);
    step(0, 1, 1, 8'h00);
    chk("ecr_pop", int'(ret_addr), 8'h34);

    // Call+return with one entry.
    step(1, 0, 0, 8'h05);
    step(1, 1, 0, 8'h40);
    chk("cr_addr", int'(ret_addr), 8'h06);
    chk("cr_jmp", int'(ret_jmp), 1);
    chk("cr_depth", int'(depth), 1);
    step(0, 1, 0, 8'h00);
    chk("cr_next", int'(ret_addr), 8'h41);

    // Wrap-around.
    step(1, 0, 0, 8'hFF);
    step(0, 1, 0, 8'h00);
    chk("wrap_addr", int'(ret_addr), 8'h00);

    // Reset asserted on a return cycle.
    step(1, 0, 0, 8'h12);
    step(1, 0, 0, 8'h13);
    step(0, 1, 0, 8'h00);
    chk("pre_rst_addr", int'(ret_addr), 8'h14);
    ret_f = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_addr", int'(ret_addr), 0);
    chk("arst_depth", int'(depth), 0);
    chk("arst_empty", int'(empty), 1);
    @(posedge clk); #1;
    chk("arst_nojmp", int'(ret_jmp), 0);
    ret_f = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0, 8'h00);
    chk("post_rst_jmp", int'(ret_jmp), 0);
    chk("post_rst_depth", int'(depth), 0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
